lfsr_rr_arbiter: RTL
====================

Name: lfsr_rr_arbiter

Overview:
Round-robin arbiter that shares one free-running WIDTH-bit LFSR random source between NUM_REQ requesters.
- Samples the LFSR output and returns it, registered, to exactly one winner per grant.
- Enforces a one-cycle gap between grants.
- Detects the all-zero LFSR lockup state and blocks grants while it persists.
- Keeps a saturating grant counter for peripheral status readback.
- Sits between the LFSR and the peripheral-side consumers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, LFSR / random word width
CNT_W, 8, grant counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_i  input  NUM_REQ  level request per requester; bit k = requester k
lfsr_i  input  WIDTH  current LFSR state (lfsr_o of the LFSR)
err_clr_i  input  1  clears the sticky lockup error
gnt_o  output  NUM_REQ  one-hot grant pulse, 1 cycle
rnd_o  output  WIDTH  random word delivered with the grant
rnd_valid_o  output  1  rnd_o valid; high exactly when gnt_o != 0
busy_o  output  1  high in GAP state
lock_err_o  output  1  sticky: lfsr_i == 0 seen at an arbitration point
grant_cnt_o  output  CNT_W  total grants issued, saturating at all-ones

Behaviour:
- Reset (reset == 0, async) values:
  - gnt_o = 0, rnd_o = 0, rnd_valid_o = 0, busy_o = 0, lock_err_o = 0, grant_cnt_o = 0.
  - State = IDLE; priority pointer ptr = 0 (requester 0 highest).
- Reset mid-operation: a pending grant is dropped, no partial pulse is produced, and all state returns to the reset values immediately.
- FSM states: IDLE, GAP.
- IDLE: arbitration point each cycle. At a rising edge with (|req_i) and lfsr_i != 0 and lock_err_o == 0:
  - Winner w = first set req_i bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: gnt_o = 1<<w, rnd_valid_o = 1, rnd_o = lfsr_i sampled at that edge.
  - ptr <= (w+1) mod NUM_REQ.
  - grant_cnt_o increments, holding at 2^CNT_W-1.
  - State <= GAP.
- IDLE with no request: outputs stay idle; ptr is unchanged.
- Latency: request sampled at edge t, so gnt_o/rnd_o are visible from edge t until edge t+1.
- GAP: gnt_o = 0, rnd_valid_o = 0, busy_o = 1. req_i is ignored and is not latched. State <= IDLE unconditionally after 1 cycle.
- Peak throughput: 1 grant per 2 cycles.
- Requester handshake: a requester must deassert req_i within the GAP cycle if it wants no further word. A req still high in IDLE is a new request.
- Lockup: in IDLE with (|req_i) and lfsr_i == 0:
  - No grant; lock_err_o <= 1; ptr unchanged; state stays IDLE.
  - While lock_err_o == 1, no grants are issued regardless of req_i and lfsr_i.
- Error clear: err_clr_i == 1 clears lock_err_o at the next edge. If a lockup is detected in the same cycle, set wins and lock_err_o stays 1.
- lfsr_i is never checked outside IDLE arbitration points.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,... Any waiting requester is granted within NUM_REQ grants.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset and idle: hold reset = 0 for 2 cycles, then release with req_i = 0 for 10 cycles -> all outputs stay 0 and busy_o stays 0.
2. Single requester: req_i = 4'b0100, lfsr_i = 4'hB -> the cycle after sampling, gnt_o = 4'b0100, rnd_o = 4'hB, rnd_valid_o = 1 for 1 cycle, then busy_o = 1 for 1 cycle. grant_cnt_o = 1; ptr = 3, checked by next test ordering.
3. Full contention: req_i = 4'b1111 held for 8 grants, bench steps lfsr_i each cycle 1,2,4,9,3,6,D,A,... -> gnt_o sequence 0001,0010,0100,1000,0001,... spaced 2 cycles apart. Each rnd_o equals lfsr_i at its sampling edge; grant_cnt_o = 8.
4. Lockup: req_i = 4'b0001, lfsr_i = 0 -> no grant and lock_err_o = 1. Set lfsr_i = 4'h5 with no clear -> still no grant. Assert err_clr_i 1 cycle -> lock_err_o = 0 and the grant follows with rnd_o = 4'h5. Assert err_clr_i while lfsr_i = 0 and req high -> lock_err_o stays 1.
5. Reset mid-grant: assert reset low in the cycle gnt_o = 4'b0010 -> gnt_o, rnd_valid_o and grant_cnt_o go 0 immediately. After release with req_i = 4'b1111, the first grant is 4'b0001.
6. Counter saturation: keep req_i = 4'b0001 for 300 grants -> grant_cnt_o reaches 8'hFF and holds while grants continue normally.

Source files
------------

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR word between NUM_REQ requesters.
// One grant per two cycles; an all-zero LFSR at an arbitration point raises a sticky lockup error.
module lfsr_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [WIDTH-1:0]   lfsr_i,
  input  logic               err_clr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [WIDTH-1:0]   rnd_o,
  output logic               rnd_valid_o,
  output logic               busy_o,
  output logic               lock_err_o,
  output logic [CNT_W-1:0]   grant_cnt_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   rnd_q, rnd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [PTR_W-1:0]   win;
  int unsigned        idx;

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_i[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    lock_d  = lock_q;
    cnt_d   = cnt_q;

    if (err_clr_i) begin
      lock_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          if (lfsr_i == '0) begin
            // Lockup detection overrides a same-cycle clear.
            lock_d = 1'b1;
          end else if (!lock_q && found) begin
            gnt_d[win] = 1'b1;
            rnd_d      = lfsr_i;
            valid_d    = 1'b1;
            ptr_d      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
            cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_o       = rnd_q;
  assign rnd_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign lock_err_o  = lock_q;
  assign grant_cnt_o = cnt_q;

endmodule
